axil_sram_responder: RTL and testbench
======================================

# axil_sram_responder

- AXI4-Lite responder (subordinate) that owns a word-addressed SRAM array.
- Answers the arbiter's read (AR/R) and write (AW/W/B) requests, each after a programmable delay.
- Sits on the memory side of the core's bus, opposite the IFU/LSU arbiter, and replaces the flat memory model for bus-level bring-up.
- Read and write paths are independent state machines that share only the array and the delay source.

## Interface
Parameters:
- ADDR_W, 10, word-index width; the array holds 2^ADDR_W 32-bit words
- BASE, 32'h8000_0000, byte base address of the array; must be aligned to 2^(ADDR_W+2)
- DELAY, 3'd1, fixed response delay in cycles (0..7), used when randomisation is compiled out

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all control state immediately
- io_ar_valid / io_ar_ready  in / out  1 / 1  read-address handshake
- io_ar_addr  in  32  read byte address
- io_r_valid / io_r_ready  out / in  1 / 1  read-data handshake
- io_r_data  out  32  read data
- io_r_resp  out  2  2'b00 OKAY, 2'b10 SLVERR
- io_aw_valid / io_aw_ready  in / out  1 / 1  write-address handshake
- io_aw_addr  in  32  write byte address
- io_w_valid / io_w_ready  in / out  1 / 1  write-data handshake
- io_w_data  in  32  write data
- io_w_strb  in  4  byte enables; bit i covers data[8i+7:8i]
- io_b_valid / io_b_ready  out / in  1 / 1  write-response handshake
- io_b_resp  out  2  2'b00 OKAY, 2'b10 SLVERR

## Operation
Address decoding:
- Word index is addr[ADDR_W+1:2]; addr[1:0] is ignored.
- An address is in range when addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]. Out of range gives SLVERR: no array write, and rdata = 0.

Read FSM: R_IDLE -> R_WAIT -> R_RESP.
- R_IDLE: io_ar_ready=1. On ar handshake, latch address, load cnt with delay d, go to R_WAIT.
- R_WAIT: if cnt==0, register array data (or 0) and resp, then go to R_RESP; otherwise cnt-1.
- R_RESP: io_r_valid=1, with data and resp held stable. On r handshake, go to R_IDLE.

Write FSM: W_IDLE -> W_WAIT -> W_RESP.
- W_IDLE: io_aw_ready=1 until AW is latched; io_w_ready=1 until W is latched. AW and W are accepted in any order or in the same cycle.
- When both are latched (including a same-cycle capture), load cnt with d and go to W_WAIT.
- W_WAIT: if cnt==0, commit the write and register bresp, then go to W_RESP. The commit writes only the enabled bytes (merged with the strobes); a strobe of 4'b0000 writes nothing but still returns OKAY.
- W_RESP: io_b_valid=1. On b handshake, clear the latched flags and go to W_IDLE.

Collision:
- When a read captures and a write commits on the same edge at the same word, the read returns the old data.

Array:
- The array is not cleared by reset.
- Reset mid-transaction drops the transaction: no R or B response is issued and no commit occurs.

## Timing
Reset values:
- io_ar_ready=1, io_aw_ready=1, io_w_ready=1
- io_r_valid=0, io_b_valid=0
- io_r_data=0, io_r_resp=0, io_b_resp=0

Latency (d = sampled delay):
- Read: ar handshake in cycle T gives io_r_valid first high in cycle T+d+2. Minimum is 2.
- Write: with Tlast = the later of the aw/w handshake cycles, io_b_valid first high in cycle Tlast+d+2.

Handshake rules:
- Valid outputs never depend combinationally on io_r_ready or io_b_ready.
- Once asserted, io_r_valid and io_b_valid stay high with stable payload until accepted.
- No new AR is accepted until R completes; no new AW/W until B completes (one outstanding transaction per direction).
- io_r_ready or io_b_ready held low stalls the FSM in its RESP state indefinitely.

## Configuration
Macro RAND_DELAY_EN:
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h5A on reset) advances every cycle, and d = lfsr[2:0], sampled in the cycle each FSM loads cnt.
- Not defined: d = DELAY for every transaction, and no LFSR is instantiated.

## Test plan
- Write then read, DELAY=1: write aw=0x8000_0010, w=0xDEAD_BEEF, strb=4'hF, then read the same address. Expect bresp=OKAY with io_b_valid 3 cycles after the later handshake, then rdata=0xDEAD_BEEF with io_r_valid 3 cycles after the ar handshake.
- Byte strobes: after the word holds 0x1122_3344, write w=0xAABB_CCDD with strb=4'b0101. A readback returns 0x11BB_33DD.
- Split address/data: W arrives 4 cycles before AW. Expect io_w_ready to drop after the W handshake, io_aw_ready to stay high until AW, and one B response.
- Out of range: read 0x0000_0000. Expect rresp=2'b10 and rdata=0. A write to 0x9000_0000 gives bresp=2'b10 and the array is unchanged.
- Backpressure and collision: hold io_r_ready=0 for 10 cycles; rvalid and rdata stay stable. A same-word read and write completing on the same edge returns the old value.
- Reset and configuration: assert reset in W_WAIT; no B is issued, the word is unchanged, and all ready signals read 1 during reset. With RAND_DELAY_EN defined, every measured latency lies in the range 2..9.

Source files
------------

// File: rtl/axil_sram_responder.sv
// AXI4-Lite responder owning a word-addressed SRAM, with independent read and write FSMs.
// Define RAND_DELAY_EN to draw each response delay from a free-running LFSR instead of DELAY.
//
// state  | meaning
// R_IDLE | AR accepted; waiting for a read request
// R_WAIT | counting down the response delay
// R_RESP | R payload held until accepted
// W_IDLE | AW and W accepted independently until both are latched
// W_WAIT | counting down the response delay; commit on terminal count
// W_RESP | B response held until accepted
module axil_sram_responder #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter logic [2:0]  DELAY  = 3'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_ar_valid,
    output logic        io_ar_ready,
    input  logic [31:0] io_ar_addr,
    output logic        io_r_valid,
    input  logic        io_r_ready,
    output logic [31:0] io_r_data,
    output logic [1:0]  io_r_resp,
    input  logic        io_aw_valid,
    output logic        io_aw_ready,
    input  logic [31:0] io_aw_addr,
    input  logic        io_w_valid,
    output logic        io_w_ready,
    input  logic [31:0] io_w_data,
    input  logic [3:0]  io_w_strb,
    output logic        io_b_valid,
    input  logic        io_b_ready,
    output logic [1:0]  io_b_resp
);

    localparam int         DEPTH       = 1 << ADDR_W;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    logic [31:0] mem_q [DEPTH];

    logic [2:0] dly;

`ifdef RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [2:0] unused_delay;

    assign unused_delay = DELAY;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 8'h5A;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dly = lfsr_q[2:0];
`else
    assign dly = DELAY;
`endif

    // Byte offset bits carry no meaning for a word-wide array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{io_ar_addr[1:0], io_aw_addr[1:0]};

    logic ar_hit, aw_hit;
    assign ar_hit = (io_ar_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    assign aw_hit = (io_aw_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);

    r_state_e          r_state_q, r_state_d;
    logic [2:0]        r_cnt_q, r_cnt_d;
    logic              r_hit_q, r_hit_d;
    logic [ADDR_W-1:0] r_idx_q, r_idx_d;
    logic [31:0]       r_data_q, r_data_d;
    logic [1:0]        r_resp_q, r_resp_d;

    always_comb begin
        r_state_d   = r_state_q;
        r_cnt_d     = r_cnt_q;
        r_hit_d     = r_hit_q;
        r_idx_d     = r_idx_q;
        r_data_d    = r_data_q;
        r_resp_d    = r_resp_q;
        io_ar_ready = 1'b0;
        io_r_valid  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                io_ar_ready = 1'b1;
                if (io_ar_valid) begin
                    r_hit_d   = ar_hit;
                    r_idx_d   = io_ar_addr[ADDR_W+1:2];
                    r_cnt_d   = dly;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 3'd0) begin
                    // Sampled before any same-edge commit lands, so a colliding write is not seen.
                    r_data_d  = r_hit_q ? mem_q[r_idx_q] : 32'h0;
                    r_resp_d  = r_hit_q ? RESP_OKAY : RESP_SLVERR;
                    r_state_d = R_RESP;
                end else begin
                    r_cnt_d = r_cnt_q - 3'd1;
                end
            end
            R_RESP: begin
                io_r_valid = 1'b1;
                if (io_r_ready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= 3'd0;
            r_hit_q   <= 1'b0;
            r_idx_q   <= '0;
            r_data_q  <= 32'h0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_hit_q   <= r_hit_d;
            r_idx_q   <= r_idx_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
        end
    end

    assign io_r_data = r_data_q;
    assign io_r_resp = r_resp_q;

    w_state_e          w_state_q, w_state_d;
    logic [2:0]        w_cnt_q, w_cnt_d;
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic              w_hit_q, w_hit_d;
    logic [ADDR_W-1:0] w_idx_q, w_idx_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic [1:0]        b_resp_q, b_resp_d;
    logic              mem_we;

    always_comb begin
        w_state_d   = w_state_q;
        w_cnt_d     = w_cnt_q;
        aw_got_d    = aw_got_q;
        w_got_d     = w_got_q;
        w_hit_d     = w_hit_q;
        w_idx_d     = w_idx_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        b_resp_d    = b_resp_q;
        mem_we      = 1'b0;
        io_aw_ready = 1'b0;
        io_w_ready  = 1'b0;
        io_b_valid  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                io_aw_ready = !aw_got_q;
                io_w_ready  = !w_got_q;
                if (io_aw_valid && !aw_got_q) begin
                    aw_got_d = 1'b1;
                    w_hit_d  = aw_hit;
                    w_idx_d  = io_aw_addr[ADDR_W+1:2];
                end
                if (io_w_valid && !w_got_q) begin
                    w_got_d  = 1'b1;
                    w_data_d = io_w_data;
                    w_strb_d = io_w_strb;
                end
                if (aw_got_d && w_got_d) begin
                    w_cnt_d   = dly;
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == 3'd0) begin
                    mem_we    = w_hit_q;
                    b_resp_d  = w_hit_q ? RESP_OKAY : RESP_SLVERR;
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q - 3'd1;
                end
            end
            W_RESP: begin
                io_b_valid = 1'b1;
                if (io_b_ready) begin
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= 3'd0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            w_hit_q   <= 1'b0;
            w_idx_q   <= '0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            w_hit_q   <= w_hit_d;
            w_idx_q   <= w_idx_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_resp_q  <= b_resp_d;
        end
    end

    assign io_b_resp = b_resp_q;

    // Array contents survive reset; only enabled bytes are touched.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && w_strb_q[i]) begin
                mem_q[w_idx_q][8*i +: 8] <= w_data_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axil_sram_responder.sv
// Self-checking bench for axil_sram_responder: directed scenarios plus a randomized
// transaction mix checked against an array model of the SRAM.
module tb_axil_sram_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [2:0]  DELAY = 3'd1;
    localparam int          EXP_LAT = DELAY + 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_ar_valid = 1'b0;
    logic        io_ar_ready;
    logic [31:0] io_ar_addr = 32'h0;
    logic        io_r_valid;
    logic        io_r_ready = 1'b1;
    logic [31:0] io_r_data;
    logic [1:0]  io_r_resp;
    logic        io_aw_valid = 1'b0;
    logic        io_aw_ready;
    logic [31:0] io_aw_addr = 32'h0;
    logic        io_w_valid = 1'b0;
    logic        io_w_ready;
    logic [31:0] io_w_data = 32'h0;
    logic [3:0]  io_w_strb = 4'h0;
    logic        io_b_valid;
    logic        io_b_ready = 1'b1;
    logic [1:0]  io_b_resp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] mdl [0:1023];

    axil_sram_responder #(.ADDR_W(10), .BASE(BASE), .DELAY(DELAY)) dut (
        .clock(clock), .reset(reset),
        .io_ar_valid(io_ar_valid), .io_ar_ready(io_ar_ready), .io_ar_addr(io_ar_addr),
        .io_r_valid(io_r_valid), .io_r_ready(io_r_ready), .io_r_data(io_r_data), .io_r_resp(io_r_resp),
        .io_aw_valid(io_aw_valid), .io_aw_ready(io_aw_ready), .io_aw_addr(io_aw_addr),
        .io_w_valid(io_w_valid), .io_w_ready(io_w_ready), .io_w_data(io_w_data), .io_w_strb(io_w_strb),
        .io_b_valid(io_b_valid), .io_b_ready(io_b_ready), .io_b_resp(io_b_resp)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic bit in_range(logic [31:0] a);
        return (a >> 12) == (BASE >> 12);
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        if (!in_range(a)) return 32'h0;
        return mdl[a[11:2]];
    endfunction

    function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
        if (in_range(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) mdl[a[11:2]][8*i +: 8] = d[8*i +: 8];
            end
        end
    endfunction

    function automatic bit lat_ok(int lat);
`ifdef RAND_DELAY_EN
        return lat >= 2 && lat <= 9;
`else
        return lat == EXP_LAT;
`endif
    endfunction

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int t_hs;
        int n;
        t_hs = -1; lat = -1; data = 32'h0; resp = 2'b00;
        @(posedge clock); #1;
        io_ar_valid = 1'b1; io_ar_addr = addr;
        n = 0;
        while (t_hs < 0 && n < 50) begin
            @(negedge clock);
            if (io_ar_ready) t_hs = cyc;
            @(posedge clock); #1;
            n++;
        end
        io_ar_valid = 1'b0;
        if (t_hs < 0) return;
        n = 0;
        while (lat < 0 && n < 50) begin
            @(negedge clock);
            if (io_r_valid) begin
                lat = cyc - t_hs; data = io_r_data; resp = io_r_resp;
            end
            n++;
        end
        @(posedge clock); #1;
    endtask

    // W is presented w_lead cycles before AW (0 = same cycle); bad counts cycles between
    // the W and AW handshakes where w_ready is not low or aw_ready is not high.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, output logic [1:0] resp, output int lat, output int bad);
        int tw, ta, k, n, tl;
        tw = -1; ta = -1; k = 0; bad = 0; lat = -1; resp = 2'b00;
        @(posedge clock); #1;
        io_w_valid = 1'b1; io_w_data = data; io_w_strb = strb; io_aw_addr = addr;
        if (w_lead == 0) io_aw_valid = 1'b1;
        while ((tw < 0 || ta < 0) && k < 60) begin
            @(negedge clock);
            if (tw >= 0 && ta < 0 && (io_w_ready !== 1'b0 || io_aw_ready !== 1'b1)) bad++;
            if (tw < 0 && io_w_valid && io_w_ready) tw = cyc;
            if (ta < 0 && io_aw_valid && io_aw_ready) ta = cyc;
            @(posedge clock); #1;
            k++;
            if (tw >= 0) io_w_valid = 1'b0;
            if (ta >= 0) io_aw_valid = 1'b0;
            else if (k >= w_lead) io_aw_valid = 1'b1;
        end
        io_w_valid = 1'b0; io_aw_valid = 1'b0;
        if (tw < 0 || ta < 0) return;
        tl = (tw > ta) ? tw : ta;
        n = 0;
        while (lat < 0 && n < 50) begin
            @(negedge clock);
            if (io_b_valid) begin
                lat = cyc - tl; resp = io_b_resp;
            end
            n++;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        #23;
        checks++; if (io_ar_ready !== 1'b1) begin errors++; $display("FAIL reset ar_ready: got %b want 1", io_ar_ready); end
        checks++; if (io_aw_ready !== 1'b1) begin errors++; $display("FAIL reset aw_ready: got %b want 1", io_aw_ready); end
        checks++; if (io_w_ready !== 1'b1) begin errors++; $display("FAIL reset w_ready: got %b want 1", io_w_ready); end
        checks++; if (io_r_valid !== 1'b0) begin errors++; $display("FAIL reset r_valid: got %b want 0", io_r_valid); end
        checks++; if (io_b_valid !== 1'b0) begin errors++; $display("FAIL reset b_valid: got %b want 0", io_b_valid); end
        checks++; if (io_r_data !== 32'h0) begin errors++; $display("FAIL reset r_data: got %h want 0", io_r_data); end
        checks++; if (io_r_resp !== 2'b00) begin errors++; $display("FAIL reset r_resp: got %b want 00", io_r_resp); end
        checks++; if (io_b_resp !== 2'b00) begin errors++; $display("FAIL reset b_resp: got %b want 00", io_b_resp); end
        @(negedge clock); reset = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic [1:0] rs; int lat, bad;
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rs, lat, bad);
        model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        checks++; if (rs !== 2'b00) begin errors++; $display("FAIL wr bresp: got %b want 00", rs); end
        checks++; if (!lat_ok(lat)) begin errors++; $display("FAIL wr b latency: got %0d want %0d", lat, EXP_LAT); end
        do_read(32'h8000_0010, d, rs, lat);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd data: got %h want deadbeef", d); end
        checks++; if (rs !== 2'b00) begin errors++; $display("FAIL rd rresp: got %b want 00", rs); end
        checks++; if (!lat_ok(lat)) begin errors++; $display("FAIL rd r latency: got %0d want %0d", lat, EXP_LAT); end
    endtask

    task automatic test_strobes();
        logic [31:0] d; logic [1:0] rs; int lat, bad;
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, rs, lat, bad);
        do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, rs, lat, bad);
        checks++; if (rs !== 2'b00) begin errors++; $display("FAIL strb bresp: got %b want 00", rs); end
        do_read(32'h8000_0020, d, rs, lat);
        checks++; if (d !== 32'h11BB_33DD) begin errors++; $display("FAIL strb merge: got %h want 11bb33dd", d); end
        do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 0, rs, lat, bad);
        checks++; if (rs !== 2'b00) begin errors++; $display("FAIL strb0 bresp: got %b want 00", rs); end
        do_read(32'h8000_0023, d, rs, lat);
        checks++; if (d !== 32'h11BB_33DD) begin errors++; $display("FAIL strb0 unchanged: got %h want 11bb33dd", d); end
        model_write(32'h8000_0020, 32'h11BB_33DD, 4'hF);
    endtask

    task automatic test_split();
        logic [31:0] d; logic [1:0] rs; int lat, bad, extra;
        do_write(32'h8000_0040, 32'h1234_5678, 4'hF, 4, rs, lat, bad);
        model_write(32'h8000_0040, 32'h1234_5678, 4'hF);
        checks++; if (bad !== 0) begin errors++; $display("FAIL split ready: %0d bad cycles, want 0", bad); end
        checks++; if (rs !== 2'b00) begin errors++; $display("FAIL split bresp: got %b want 00", rs); end
        checks++; if (!lat_ok(lat)) begin errors++; $display("FAIL split latency: got %0d want %0d", lat, EXP_LAT); end
        extra = 0;
        repeat (10) begin
            @(negedge clock);
            if (io_b_valid) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL split single B: %0d extra B cycles, want 0", extra); end
        do_read(32'h8000_0040, d, rs, lat);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL split readback: got %h want 12345678", d); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] rs; int lat, bad;
        do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, rs, lat, bad);
        model_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF);
        do_read(32'h0000_0000, d, rs, lat);
        checks++; if (rs !== 2'b10) begin errors++; $display("FAIL oor rresp: got %b want 10", rs); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor rdata: got %h want 0", d); end
        do_write(32'h9000_0000, 32'h5555_5555, 4'hF, 0, rs, lat, bad);
        checks++; if (rs !== 2'b10) begin errors++; $display("FAIL oor bresp: got %b want 10", rs); end
        do_read(32'h8000_0000, d, rs, lat);
        checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL oor array unchanged: got %h want cafef00d", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d, d0; int n, unstable; bit hs, seen;
        exp_d = model_read(32'h8000_0010);
        io_r_ready = 1'b0;
        @(posedge clock); #1;
        io_ar_valid = 1'b1; io_ar_addr = 32'h8000_0010;
        @(negedge clock); hs = io_ar_ready;
        @(posedge clock); #1; io_ar_valid = 1'b0;
        seen = 1'b0; n = 0; d0 = 32'h0;
        while (!seen && n < 50) begin
            @(negedge clock);
            if (io_r_valid) begin seen = 1'b1; d0 = io_r_data; end
            n++;
        end
        checks++; if (!(hs && seen)) begin errors++; $display("FAIL bp rvalid: ar_hs=%0d seen=%0d want 1/1", hs, seen); end
        checks++; if (d0 !== exp_d) begin errors++; $display("FAIL bp rdata: got %h want %h", d0, exp_d); end
        unstable = 0;
        repeat (10) begin
            @(negedge clock);
            if (io_r_valid !== 1'b1 || io_r_data !== exp_d) unstable++;
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL bp stable: %0d unstable cycles, want 0", unstable); end
        io_r_ready = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (io_r_valid !== 1'b0) begin errors++; $display("FAIL bp release: r_valid %b want 0", io_r_valid); end
    endtask

    task automatic test_collision();
        logic [31:0] d, rd; logic [1:0] rs, br; int lat, bad, n; bit hs, got_r, got_b;
        do_write(32'h8000_0080, 32'h0BAD_0001, 4'hF, 0, rs, lat, bad);
        @(posedge clock); #1;
        io_ar_valid = 1'b1; io_ar_addr = 32'h8000_0080;
        io_aw_valid = 1'b1; io_aw_addr = 32'h8000_0080;
        io_w_valid = 1'b1; io_w_data = 32'h600D_0002; io_w_strb = 4'hF;
        @(negedge clock); hs = io_ar_ready && io_aw_ready && io_w_ready;
        @(posedge clock); #1;
        io_ar_valid = 1'b0; io_aw_valid = 1'b0; io_w_valid = 1'b0;
        got_r = 1'b0; got_b = 1'b0; n = 0; rd = 32'h0; br = 2'b11;
        while ((!got_r || !got_b) && n < 50) begin
            @(negedge clock);
            if (io_r_valid && !got_r) begin got_r = 1'b1; rd = io_r_data; end
            if (io_b_valid && !got_b) begin got_b = 1'b1; br = io_b_resp; end
            n++;
        end
        @(posedge clock); #1;
        checks++; if (!(hs && got_r && got_b)) begin errors++; $display("FAIL coll handshakes: hs=%0d r=%0d b=%0d want 1/1/1", hs, got_r, got_b); end
        checks++; if (rd !== 32'h0BAD_0001) begin errors++; $display("FAIL coll old data: got %h want 0bad0001", rd); end
        checks++; if (br !== 2'b00) begin errors++; $display("FAIL coll bresp: got %b want 00", br); end
        model_write(32'h8000_0080, 32'h600D_0002, 4'hF);
        do_read(32'h8000_0080, d, rs, lat);
        checks++; if (d !== 32'h600D_0002) begin errors++; $display("FAIL coll new data: got %h want 600d0002", d); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, got; logic [1:0] rs, exp_rs; int lat, bad;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            do_write(32'h8000_0400 + 32'(4*i), d, 4'hF, 0, rs, lat, bad);
            model_write(32'h8000_0400 + 32'(4*i), d, 4'hF);
        end
        for (int t = 0; t < 60; t++) begin
            a = 32'h8000_0400 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
                if (in_range(a)) a = a ^ 32'h4000_0000;
            end
            exp_rs = in_range(a) ? 2'b00 : 2'b10;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), rs, lat, bad);
                model_write(a, d, io_w_strb);
                checks++; if (rs !== exp_rs) begin errors++; $display("FAIL rand bresp @%h: got %b want %b", a, rs, exp_rs); end
                checks++; if (!lat_ok(lat)) begin errors++; $display("FAIL rand b latency @%h: got %0d", a, lat); end
            end else begin
                do_read(a, got, rs, lat);
                checks++; if (got !== model_read(a)) begin errors++; $display("FAIL rand rdata @%h: got %h want %h", a, got, model_read(a)); end
                checks++; if (rs !== exp_rs) begin errors++; $display("FAIL rand rresp @%h: got %b want %b", a, rs, exp_rs); end
                checks++; if (!lat_ok(lat)) begin errors++; $display("FAIL rand r latency @%h: got %0d", a, lat); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d; logic [1:0] rs; int lat, bad, bcnt; bit hs, rdy_ok;
        do_write(32'h8000_0100, 32'h7777_0000, 4'hF, 0, rs, lat, bad);
        model_write(32'h8000_0100, 32'h7777_0000, 4'hF);
        @(posedge clock); #1;
        io_aw_valid = 1'b1; io_aw_addr = 32'h8000_0100;
        io_w_valid = 1'b1; io_w_data = 32'h1234_5678; io_w_strb = 4'hF;
        @(negedge clock); hs = io_aw_ready && io_w_ready;
        @(posedge clock); #1;
        io_aw_valid = 1'b0; io_w_valid = 1'b0;
        @(negedge clock); reset = 1'b0;
        #1;
        rdy_ok = io_ar_ready && io_aw_ready && io_w_ready && !io_b_valid && !io_r_valid;
        checks++; if (!(hs && rdy_ok)) begin errors++; $display("FAIL rst readies: hs=%0d ok=%0d want 1/1", hs, rdy_ok); end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        bcnt = 0;
        repeat (15) begin
            @(negedge clock);
            if (io_b_valid) bcnt++;
        end
        checks++; if (bcnt !== 0) begin errors++; $display("FAIL rst no B: %0d B cycles, want 0", bcnt); end
        do_read(32'h8000_0100, d, rs, lat);
        checks++; if (d !== 32'h7777_0000) begin errors++; $display("FAIL rst word unchanged: got %h want 77770000", d); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_split();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
